// File: rtl/set_assoc_cache.sv
// Set-associative tag store with true-LRU replacement, a single outstanding line fill
// and saturating hit/miss/read statistics.
module set_assoc_cache #(
    parameter int WAYS  = 4,
    parameter int IDX_W = 14,
    parameter int OFF_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_n,
    input  logic [31:0]       cmd_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              mem_req,
    output logic [31-OFF_W:0] mem_addr,
    input  logic              mem_ack,
    output logic [31:0]       hits,
    output logic [31:0]       misses,
    output logic [31:0]       reads
);

    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << IDX_W;

    localparam logic [3:0] OP_CLEAR = 4'd8;
    localparam logic [3:0] OP_INV   = 4'd3;
    localparam logic [3:0] OP_FETCH = 4'd2;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_RESP
    } state_t;

    state_t state, state_nx;

    logic [WAYS-1:0]  valid_mem [SETS];
    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [WAY_W-1:0] age_mem   [SETS][WAYS];

    logic [IDX_W-1:0] clr_idx;
    logic             req_fetch;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;

    logic             accept;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             found_inv;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] victim_way;
    logic             inv_en;
    logic             fill_en;
    logic             mru_en;
    logic [WAY_W-1:0] mru_way;

    // Byte-offset bits never reach the tag store.
    logic unused_offset;
    assign unused_offset = ^cmd_addr[OFF_W-1:0];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign accept = cmd_valid & cmd_ready;

    // Tag match and victim selection for the set latched at accept time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        // Descending scan so the lowest-numbered qualifying way is the one left standing.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_mem[req_idx][w]) begin
                found_inv = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_mem[req_idx][w] == WAY_W'(WAYS - 1)) begin
                lru_way = WAY_W'(w);
            end
        end
        victim_way = found_inv ? inv_way : lru_way;
    end

    assign inv_en  = (state == S_LOOKUP) && !req_fetch && hit;
    assign fill_en = (state == S_FILL) && mem_ack;
    assign mru_en  = ((state == S_LOOKUP) && req_fetch && hit) || fill_en;
    assign mru_way = fill_en ? victim_way : hit_way;

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_req   = 1'b0;
        case (state)
            S_CLEAR: begin
                if (&clr_idx) state_nx = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    case (cmd_n)
                        OP_CLEAR:        state_nx = S_CLEAR;
                        OP_FETCH, OP_INV: state_nx = S_LOOKUP;
                        default:         state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOOKUP: begin
                state_nx = (req_fetch && !hit) ? S_FILL : S_RESP;
            end
            S_FILL: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_CLEAR;
        endcase
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_idx   <= '0;
            req_fetch <= 1'b0;
            req_tag   <= '0;
            req_idx   <= '0;
            rsp_hit   <= 1'b0;
            mem_addr  <= '0;
            hits      <= '0;
            misses    <= '0;
            reads     <= '0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR) begin
                clr_idx <= clr_idx + IDX_W'(1);
            end
            if (accept) begin
                req_fetch <= (cmd_n == OP_FETCH);
                req_tag   <= cmd_addr[31 -: TAG_W];
                req_idx   <= cmd_addr[OFF_W +: IDX_W];
                if (cmd_n == OP_CLEAR) begin
                    clr_idx <= '0;
                    hits    <= '0;
                    misses  <= '0;
                    reads   <= '0;
                end
                if (cmd_n == OP_FETCH) begin
                    reads <= sat_inc(reads);
                end
            end
            if (state == S_LOOKUP) begin
                rsp_hit <= hit;
                if (req_fetch && hit) begin
                    hits <= sat_inc(hits);
                end
                if (req_fetch && !hit) begin
                    misses   <= sat_inc(misses);
                    mem_addr <= {req_tag, req_idx};
                end
            end
            if (state == S_RESP) begin
                rsp_hit <= 1'b0;
            end
        end
    end

    // NOTE: the tag store has no reset; the CLEAR sweep initialises every set before first use.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            valid_mem[clr_idx] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                tag_mem[clr_idx][w] <= '0;
                age_mem[clr_idx][w] <= WAY_W'(w);
            end
        end else begin
            if (inv_en) begin
                valid_mem[req_idx][hit_way] <= 1'b0;
            end
            if (fill_en) begin
                valid_mem[req_idx][victim_way] <= 1'b1;
                tag_mem[req_idx][victim_way]   <= req_tag;
            end
            if (mru_en) begin
                // Ways younger than the touched one age by one; the touched way becomes 0.
                for (int w = 0; w < WAYS; w++) begin
                    if (age_mem[req_idx][w] < age_mem[req_idx][mru_way]) begin
                        age_mem[req_idx][w] <= age_mem[req_idx][w] + WAY_W'(1);
                    end
                end
                age_mem[req_idx][mru_way] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios plus random traffic
// compared against a recency-list model of each set.
module tb_set_assoc_cache;

    localparam int WAYS  = 4;
    localparam int IDX_W = 2;
    localparam int OFF_W = 6;
    localparam int SETS  = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_n = '0;
    logic [31:0] cmd_addr = '0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        mem_req;
    logic [25:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] hits, misses, reads;

    set_assoc_cache #(.WAYS(WAYS), .IDX_W(IDX_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_n(cmd_n), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .hits(hits), .misses(misses), .reads(reads)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-set valid/tag plus a recency list of ways, MRU first.
    bit          m_valid [SETS][WAYS];
    logic [23:0] m_tag   [SETS][WAYS];
    int          m_order [SETS][$];
    logic [31:0] m_hits, m_misses, m_reads;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic void model_clear_sets();
        for (int s = 0; s < SETS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_order[s].push_back(w);
            end
        end
    endfunction

    function automatic void model_touch(input int s, input int k);
        int pos = 0;
        for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == k) pos = i;
        m_order[s].delete(pos);
        m_order[s].push_front(k);
    endfunction

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        return m_order[s][m_order[s].size() - 1];
    endfunction

    task automatic check_counters();
        check("hits", hits, m_hits);
        check("misses", misses, m_misses);
        check("reads", reads, m_reads);
    endtask

    // Assert reset, check the immediate reset values, release and time the sweep.
    task automatic do_reset();
        cmd_valid = 1'b0;
        mem_ack   = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_rsp", 32'({rsp_valid, rsp_hit}), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_cnt", hits | misses | reads, 0);
        mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        rst     = 1'b0;
        m_hits = 0; m_misses = 0; m_reads = 0;
        model_clear_sets();
        check("sweep_ready0", 32'(cmd_ready), 0);
        for (int i = 1; i < SETS; i++) begin
            @(negedge clk);
            check("sweep_ready", 32'(cmd_ready), 0);
        end
        @(negedge clk);
        check("sweep_done", 32'(cmd_ready), 1);
        check_counters();
    endtask

    // Issue one command (held until accepted) and follow it to completion.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input int ack_dly,
                         output logic obs_hit);
        int          n;
        int          s;
        int          way;
        int          v;
        logic [23:0] t;
        bit          exp_hit;
        bit          is_fetch;
        bit          is_inv;
        s        = int'(addr[7:6]);
        t        = addr[31:8];
        is_fetch = (op == 4'd2);
        is_inv   = (op == 4'd3);
        way      = -1;
        for (int w = 0; w < WAYS; w++) if (way < 0 && m_valid[s][w] && m_tag[s][w] == t) way = w;
        exp_hit  = (way >= 0);
        obs_hit  = 1'b0;
        mem_ack  = 1'b0;

        cmd_valid = 1'b1;
        cmd_n     = op;
        cmd_addr  = addr;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 100), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_n     = 4'($urandom);
        cmd_addr  = $urandom;

        if (op == 4'd8) begin
            m_hits = 0; m_misses = 0; m_reads = 0;
            model_clear_sets();
            check("clr_busy", 32'({cmd_ready, rsp_valid}), 0);
        end else if (!is_fetch && !is_inv) begin
            check("drop_ready", 32'(cmd_ready), 1);
            check("drop_rsp", 32'(rsp_valid), 0);
            @(negedge clk);
            check("drop_rsp2", 32'(rsp_valid), 0);
        end else begin
            if (is_fetch) m_reads = sat(m_reads);
            check("lookup_quiet", 32'({cmd_ready, rsp_valid, mem_req}), 0);
            @(negedge clk);
            if (is_fetch && !exp_hit) begin
                m_misses = sat(m_misses);
                check("mem_req", 32'(mem_req), 1);
                check("mem_addr", 32'(mem_addr), 32'(addr[31:6]));
                check("miss_no_rsp", 32'(rsp_valid), 0);
                for (int i = 0; i < ack_dly; i++) begin
                    @(negedge clk);
                    check("mem_hold", 32'({mem_req, mem_addr, rsp_valid}), 32'({1'b1, addr[31:6], 1'b0}));
                end
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                v = model_victim(s);
                m_valid[s][v] = 1'b1;
                m_tag[s][v]   = t;
                model_touch(s, v);
            end else if (is_fetch) begin
                m_hits = sat(m_hits);
                model_touch(s, way);
            end else if (exp_hit) begin
                m_valid[s][way] = 1'b0;
            end
            check("rsp_valid", 32'(rsp_valid), 1);
            check("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
            check("rsp_no_req", 32'(mem_req), 0);
            obs_hit = rsp_hit;
            @(negedge clk);
            check("rsp_pulse", 32'(rsp_valid), 0);
            check("back_idle", 32'(cmd_ready), 1);
        end
        check_counters();
    endtask

    function automatic logic [31:0] mk_addr(input int tag, input int idx);
        return (32'(tag) << 8) | (32'(idx) << 6) | 32'($urandom_range(0, 63));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        logic [3:0] op;
        int r;
        @(negedge clk);
        do_reset();

        // Cold miss then hit on the same line.
        issue(4'd2, 32'h0000_0040, 3, h);
        check("t33_first_hit", 32'(h), 0);
        issue(4'd2, 32'h0000_0040, 0, h);
        check("t33_second_hit", 32'(h), 1);
        check("t33_counts", {hits[7:0], misses[7:0], reads[15:0]}, 32'h0101_0002);

        // LRU eviction in set 0.
        for (int t = 1; t <= 5; t++) begin
            issue(4'd2, mk_addr(t, 0), $urandom_range(0, 2), h);
            check("t34_fill_miss", 32'(h), 0);
        end
        issue(4'd2, mk_addr(1, 0), 1, h);
        check("t34_tag1_evicted", 32'(h), 0);
        issue(4'd2, mk_addr(3, 0), 0, h);
        check("t34_tag3_kept", 32'(h), 1);
        issue(4'd2, mk_addr(2, 0), 0, h);
        check("t34_tag2_evicted", 32'(h), 0);

        // Invalidate.
        issue(4'd2, mk_addr(7, 1), 2, h);
        issue(4'd3, mk_addr(7, 1), 0, h);
        check("t35_inv_hit", 32'(h), 1);
        issue(4'd2, mk_addr(7, 1), 0, h);
        check("t35_refetch_miss", 32'(h), 0);
        issue(4'd3, mk_addr(9, 1), 0, h);
        check("t35_inv_absent", 32'(h), 0);

        // Random traffic with stray mem_ack pulses between commands.
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 39);
            if (r < 22)      op = 4'd2;
            else if (r < 32) op = 4'd3;
            else if (r < 38) begin
                op = 4'($urandom_range(0, 15));
                while (op == 4'd2 || op == 4'd3 || op == 4'd8) op = 4'($urandom_range(0, 15));
            end else         op = 4'd8;
            issue(op, mk_addr($urandom_range(0, 5), $urandom_range(0, 3)), $urandom_range(0, 4), h);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                mem_ack = 1'($urandom);
                @(negedge clk);
            end
            mem_ack = 1'b0;
        end

        // Reset in the middle of a fill.
        cmd_valid = 1'b1;
        cmd_n     = 4'd2;
        cmd_addr  = 32'h0000_55C0;
        while (cmd_ready !== 1'b1) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t36_mem_req_up", 32'(mem_req), 1);
        do_reset();
        check("t36_after_rsp", 32'(rsp_valid), 0);
        issue(4'd2, 32'h0000_55C0, 1, h);
        check("t36_no_fill_kept", 32'(h), 0);
        issue(4'd2, 32'h0000_0040, 0, h);
        check("t36_set1_cleared", 32'(h), 0);

        // Saturation and an ignored opcode.
        force dut.reads = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.reads;
        m_reads = 32'hFFFF_FFFF;
        issue(4'd2, 32'h0000_0040, 0, h);
        check("t37_reads_sat", reads, 32'hFFFF_FFFF);
        issue(4'd5, 32'h0000_0040, 0, h);
        check("t37_reads_after_op5", reads, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-002 SHALL have parameter IDX_W, default 14, set-index bits; sets = 2^IDX_W.
REQ-003 SHALL have parameter OFF_W, default 6, line-offset bits; TAG_W = 32-IDX_W-OFF_W.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid input 1 and cmd_ready output 1, the command handshake.
REQ-007 SHALL have ports cmd_n input 4 and cmd_addr input 32, giving opcode and byte address.
REQ-008 SHALL have ports rsp_valid output 1 and rsp_hit output 1, a one-cycle completion pulse and its hit flag.
REQ-009 SHALL have ports mem_req output 1, mem_addr output 32-OFF_W and mem_ack input 1, the line-fill handshake to the next level.
REQ-010 SHALL have ports hits, misses and reads, each output 32, the statistics counters.

Function
REQ-011 SHALL split cmd_addr into tag [31:IDX_W+OFF_W] and index [IDX_W+OFF_W-1:OFF_W].
REQ-012 SHALL hold per set: WAYS valid bits, WAYS tags, WAYS log2(WAYS)-bit ages (0 = MRU).
REQ-013 SHALL implement FSM states CLEAR, IDLE, LOOKUP, FILL, RESP.
REQ-014 SHALL assert cmd_ready only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-015 SHALL decode opcodes: 8 = clear, 3 = invalidate, 2 = fetch; any other opcode SHALL be accepted and dropped with no response and no state change.
REQ-016 CLEAR SHALL sweep one set per cycle, index 0 up to 2^IDX_W-1, setting valid=0, tag=0 and age[w]=w; on the last set it SHALL go to IDLE.
REQ-017 Clear opcode SHALL zero hits, misses and reads in the accept cycle, enter CLEAR, and produce no rsp_valid.
REQ-018 On fetch acceptance, reads SHALL increment and the FSM SHALL go to LOOKUP.
REQ-019 A hit (valid way with matching tag) SHALL increment hits, set the way MRU, and pulse rsp_valid=1 with rsp_hit=1 exactly 2 cycles after acceptance.
REQ-020 A miss SHALL increment misses in LOOKUP, then in the next cycle assert mem_req with mem_addr = cmd_addr[31:OFF_W], holding both stable until mem_ack is sampled high.
REQ-021 On mem_ack, the victim SHALL be written with valid=1 and the new tag and made MRU, mem_req SHALL drop, and rsp_valid=1 with rsp_hit=0 SHALL pulse in the following cycle.
REQ-022 The victim SHALL be the lowest-numbered invalid way, else the way with age WAYS-1.
REQ-023 Making way k MRU SHALL increment every way whose age is below age[k] and set age[k]=0; ages SHALL stay a permutation of 0..WAYS-1.
REQ-024 Invalidate SHALL clear valid on the first valid way with matching tag, leave ages unchanged, and pulse rsp_valid 2 cycles after acceptance, with rsp_hit=1 if a way matched, else 0.
REQ-025 Counters SHALL saturate at 32'hFFFFFFFF and not wrap.
REQ-026 mem_ack outside FILL SHALL be ignored.
REQ-027 rsp_valid SHALL last exactly one cycle; the FSM SHALL return to IDLE in the cycle after RESP.
REQ-028 A command arriving while cmd_ready=0 SHALL be neither accepted nor lost; the requester holds it.

Reset
REQ-029 rst high SHALL force, immediately: state CLEAR, sweep index 0, cmd_ready=0, rsp_valid=0, rsp_hit=0, mem_req=0, mem_addr=0, hits/misses/reads=0.
REQ-030 On rst deassertion the full CLEAR sweep SHALL run, so cmd_ready first rises 2^IDX_W cycles later.
REQ-031 rst during FILL SHALL abandon the fill; no way is written and no response is issued.

Verification (IDX_W=2, WAYS=4, OFF_W=6)
REQ-032 Release rst -> cmd_ready=0 for 4 cycles then 1; counters=0; all ways invalid.
REQ-033 Fetch 0x00000040 twice, mem_ack 3 cycles after mem_req -> mem_addr=0x0000001; first response hit=0, second hit=1 at accept+2; reads=2, hits=1, misses=1.
REQ-034 Fetch tags 1..5 into set 0, then refetch tag 1 -> fifth fill evicts tag 1 (way 0, age 3); refetch of tag 1 misses and evicts tag 2.
REQ-035 Fetch tag 7 into set 1, then invalidate it -> rsp_hit=1; refetch misses; invalidate of an absent tag gives rsp_hit=0.
REQ-036 Assert rst while mem_req=1 -> mem_req drops at once, no rsp_valid, and the set has no valid way after the sweep.
REQ-037 Preload reads=32'hFFFFFFFF via force, then fetch -> reads remains 32'hFFFFFFFF; opcode 5 -> no rsp_valid, counters unchanged.
